// File: rtl/pipeline_types.sv
// Shared pipeline datapath types.
// control_path_t carries one-cycle press/release edge pulses from the debouncer.
package pipeline_types;

    typedef struct packed {
        logic rising;
        logic falling;
    } control_path_t;

endpackage

// File: rtl/button_event_ctrl.sv
// Button gesture classifier: turns debounced press/release pulses into short, long and
// double press events, and steps a mode index according to the classified gesture.
module button_event_ctrl #(
    parameter  int unsigned LONG_PRESS_CYCLES = 8,
    parameter  int unsigned DOUBLE_GAP_CYCLES = 4,
    parameter  int unsigned NUM_MODES         = 3,
    localparam int unsigned MODE_W            = $clog2(NUM_MODES)
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  pipeline_types::control_path_t i_control,
    output logic                          o_short_pulse,
    output logic                          o_long_pulse,
    output logic                          o_double_pulse,
    output logic [MODE_W-1:0]             o_mode,
    output logic                          o_busy
);

    // One counter serves both the hold timer and the release-gap timer.
    localparam int unsigned SPAN  = (LONG_PRESS_CYCLES > DOUBLE_GAP_CYCLES) ?
                                    LONG_PRESS_CYCLES : DOUBLE_GAP_CYCLES;
    localparam int unsigned CNT_W = $clog2(SPAN);

    localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(SPAN - 1);
    localparam logic [CNT_W-1:0]  LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(DOUBLE_GAP_CYCLES - 1);
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPressed,
        StLongHeld,
        StWaitSecond,
        StSecondPressed
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              short_q, short_d;
    logic              long_q, long_d;
    logic              double_q, double_d;

    logic              rise;
    logic              fall;
    logic [MODE_W-1:0] mode_inc;
    logic [MODE_W-1:0] mode_dec;

    // Simultaneous press and release is treated as noise.
    assign rise = i_control.rising & ~i_control.falling;
    assign fall = i_control.falling & ~i_control.rising;

    assign mode_inc = (mode_q == MODE_LAST) ? '0 : mode_q + MODE_W'(1);
    assign mode_dec = (mode_q == '0) ? MODE_LAST : mode_q - MODE_W'(1);

    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;

        // Edge checks come first in every state so they win over a same-cycle timeout.
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StPressed;
                end
            end
            StPressed: begin
                if (fall) begin
                    state_d = StWaitSecond;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = StLongHeld;
                    long_d  = 1'b1;
                end
            end
            StLongHeld: begin
                if (fall) begin
                    state_d = StIdle;
                end
            end
            StWaitSecond: begin
                if (rise) begin
                    state_d = StSecondPressed;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = StIdle;
                    short_d = 1'b1;
                end
            end
            StSecondPressed: begin
                if (fall) begin
                    state_d  = StIdle;
                    double_d = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    // A held second press is still a double press, not a long one.
                    state_d  = StLongHeld;
                    double_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        mode_d = mode_q;
        if (short_d) begin
            mode_d = mode_inc;
        end else if (double_d) begin
            mode_d = mode_dec;
        end else if (long_d) begin
            mode_d = '0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            mode_q   <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
        end
    end

    assign o_short_pulse  = short_q;
    assign o_long_pulse   = long_q;
    assign o_double_pulse = double_q;
    assign o_mode         = mode_q;
    assign o_busy         = (state_q != StIdle);

endmodule

// File: doc/button_event_ctrl.md
BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

Interface
REQ-001 The block SHALL have parameter LONG_PRESS_CYCLES, default 8: number of held cycles that classify a long press; legal values 2 and above.
REQ-002 The block SHALL have parameter DOUBLE_GAP_CYCLES, default 4: maximum released gap for a second press to count as a double press; legal values 1 and above.
REQ-003 The block SHALL have parameter NUM_MODES, default 3: number of modes; legal values 2 and above; MODE_W = $clog2(NUM_MODES).
REQ-004 i_clk  input  1  clock; reset i_reset_n, asynchronous, active-low; clock i_clk.
REQ-005 i_reset_n  input  1  asynchronous active-low reset.
REQ-006 i_control  input  pipeline_types::control_path_t  debounced edge pulses; .rising = press, .falling = release, one cycle each.
REQ-007 o_short_pulse  output  1  one-cycle pulse on a classified single short press.
REQ-008 o_long_pulse  output  1  one-cycle pulse on a classified long press.
REQ-009 o_double_pulse  output  1  one-cycle pulse on a classified double press.
REQ-010 o_mode  output  MODE_W  current mode index, range 0..NUM_MODES-1.
REQ-011 o_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 The FSM SHALL have exactly five states: IDLE, PRESSED, LONG_HELD, WAIT_SECOND and SECOND_PRESSED; o_busy = (state != IDLE).
REQ-013 A single cycle counter SHALL clear on every state transition, increment once per cycle otherwise, and saturate at max(LONG_PRESS_CYCLES, DOUBLE_GAP_CYCLES)-1.
REQ-014 In IDLE, rising SHALL transition to PRESSED, and falling SHALL be ignored.
REQ-015 In PRESSED, falling SHALL transition to WAIT_SECOND; otherwise, counter == LONG_PRESS_CYCLES-1 SHALL transition to LONG_HELD and assert o_long_pulse on the next cycle.
REQ-016 In LONG_HELD, falling SHALL transition to IDLE with no pulse, and rising SHALL be ignored.
REQ-017 In WAIT_SECOND, rising SHALL transition to SECOND_PRESSED; otherwise, counter == DOUBLE_GAP_CYCLES-1 SHALL transition to IDLE and assert o_short_pulse.
REQ-018 In SECOND_PRESSED, falling SHALL transition to IDLE and assert o_double_pulse; otherwise, counter == LONG_PRESS_CYCLES-1 SHALL transition to LONG_HELD and assert o_double_pulse, never o_long_pulse.
REQ-019 A transition condition and its input edge SHALL take priority over a timeout evaluated in the same cycle.
REQ-020 When .rising and .falling are both high in the same cycle, both SHALL be ignored.
REQ-021 All pulse outputs SHALL be registered, high for exactly one cycle, asserted in the cycle after the triggering edge or timeout is sampled, and mutually exclusive.
REQ-022 o_mode SHALL update in the same cycle its pulse is asserted.
REQ-023 A short press SHALL set o_mode to (o_mode+1) mod NUM_MODES, wrapping NUM_MODES-1 to 0.
REQ-024 A double press SHALL set o_mode to (o_mode-1) mod NUM_MODES, wrapping 0 to NUM_MODES-1.
REQ-025 A long press SHALL set o_mode to 0.
REQ-026 All mode arithmetic SHALL be MODE_W-bit, with an explicit wrap compare and no reliance on power-of-two overflow.
REQ-027 A PRESSED or SECOND_PRESSED interval shorter than LONG_PRESS_CYCLES SHALL never produce o_long_pulse.

Reset
REQ-028 On i_reset_n low, the block SHALL asynchronously force state to IDLE, the counter to 0, o_mode to 0, and o_short_pulse, o_long_pulse, o_double_pulse and o_busy to 0.
REQ-029 Reset asserted mid-sequence SHALL discard the in-progress press with no pulse emitted, during or after reset.
REQ-030 After reset release, the first rising SHALL be processed normally from IDLE.

Verification (LONG_PRESS_CYCLES=8, DOUBLE_GAP_CYCLES=4, NUM_MODES=3)
REQ-031 The bench SHALL drive rising at t, falling at t+3, then nothing -> o_short_pulse one cycle, o_mode 0->1, o_busy low afterwards.
REQ-032 The bench SHALL drive rising held with no falling for 8 cycles -> o_long_pulse one cycle at 8 cycles after PRESSED entry, o_mode ->0; a later falling -> no pulse, IDLE.
REQ-033 The bench SHALL drive rising, falling after 2 cycles, rising 2 cycles later, falling 2 cycles later -> o_double_pulse once, o_mode 0->2 (wrap), no o_short_pulse.
REQ-034 The bench SHALL apply three consecutive short presses from mode 0 -> o_mode sequence 1, 2, 0.
REQ-035 The bench SHALL drive a second rising in the same cycle the gap counter reaches 3 -> SECOND_PRESSED entered, no o_short_pulse (edge priority).
REQ-036 The bench SHALL assert i_reset_n low 5 cycles into PRESSED with o_mode=2 -> o_mode=0, o_busy=0 immediately, and no pulse through release.
